// File: rtl/adb_kbd_queue_pkg.sv
// rtl/adb_kbd_queue_pkg.sv - shared types and constants for the ADB keyboard queue
// Contents: parser state enum, queued event struct, ADB modifier keycodes,
// PS/2 prefix bytes, Pause skip length, and a helper that spots keyboard
// status/ack bytes that carry no key information.
package adb_kbd_pkg;

  typedef enum logic [2:0] {
    PS_IDLE    = 3'd0,
    PS_EXT     = 3'd1,
    PS_BRK     = 3'd2,
    PS_EXT_BRK = 3'd3,
    PS_SKIP    = 3'd4
  } parse_state_e;

  typedef struct packed {
    logic       up;
    logic [6:0] code;
  } kbd_event_t;

  localparam logic [6:0] ADB_LSHIFT = 7'h38;
  localparam logic [6:0] ADB_RSHIFT = 7'h7B;
  localparam logic [6:0] ADB_LCTRL  = 7'h36;
  localparam logic [6:0] ADB_RCTRL  = 7'h7D;
  localparam logic [6:0] ADB_LOPT   = 7'h3A;
  localparam logic [6:0] ADB_ROPT   = 7'h7C;
  localparam logic [6:0] ADB_CMD    = 7'h37;
  localparam logic [6:0] ADB_CAPS   = 7'h39;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // The Pause key sends E1 followed by seven more bytes; all of them are eaten.
  localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

  // Self-test pass, ack, echo and resend bytes from the keyboard.
  function automatic logic is_ps2_noise(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/adb_kbd_queue_if.sv
// rtl/adb_kbd_queue_if.sv - PS/2 input and key-queue output bundle
// Signals: ps2_code/ps2_valid (scancode strobe), pop/flush (GLU side controls),
// key_code/key_up/key_valid (FIFO head), modifiers, count, overflow.
// master drives the inputs of the queue; slave is the queue itself.
interface adb_kbd_queue_if #(
  parameter int CW = 4
);
  logic [7:0]    ps2_code;
  logic          ps2_valid;
  logic          pop;
  logic          flush;
  logic [6:0]    key_code;
  logic          key_up;
  logic          key_valid;
  logic [4:0]    modifiers;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output ps2_code, ps2_valid, pop, flush,
    input  key_code, key_up, key_valid, modifiers, count, overflow
  );

  modport slave (
    input  ps2_code, ps2_valid, pop, flush,
    output key_code, key_up, key_valid, modifiers, count, overflow
  );
endinterface

// File: rtl/adb_kbd_xlate.sv
// rtl/adb_kbd_xlate.sv - registered PS/2 set-2 to ADB keycode lookup
// Ports: clk, reset; ext/code select the scancode ({ext, code[7:0]});
// hit/adb give the registered result one cycle later (hit=0: unmapped).
module adb_kbd_xlate (
  input  logic       clk,
  input  logic       reset,
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [6:0] adb
);

  logic       hit_d;
  logic [6:0] adb_d;

  // Extended 12 and 59 (fake shifts) fall through to the unmapped default.
  always_comb begin
    hit_d = 1'b1;
    adb_d = 7'h00;
    case ({ext, code})
      9'h01C: adb_d = 7'h00;  9'h01B: adb_d = 7'h01;  9'h023: adb_d = 7'h02;
      9'h02B: adb_d = 7'h03;  9'h033: adb_d = 7'h04;  9'h034: adb_d = 7'h05;
      9'h01A: adb_d = 7'h06;  9'h022: adb_d = 7'h07;  9'h021: adb_d = 7'h08;
      9'h02A: adb_d = 7'h09;  9'h032: adb_d = 7'h0B;  9'h015: adb_d = 7'h0C;
      9'h01D: adb_d = 7'h0D;  9'h024: adb_d = 7'h0E;  9'h02D: adb_d = 7'h0F;
      9'h035: adb_d = 7'h10;  9'h02C: adb_d = 7'h11;  9'h016: adb_d = 7'h12;
      9'h01E: adb_d = 7'h13;  9'h026: adb_d = 7'h14;  9'h025: adb_d = 7'h15;
      9'h036: adb_d = 7'h16;  9'h02E: adb_d = 7'h17;  9'h055: adb_d = 7'h18;
      9'h046: adb_d = 7'h19;  9'h03D: adb_d = 7'h1A;  9'h04E: adb_d = 7'h1B;
      9'h03E: adb_d = 7'h1C;  9'h045: adb_d = 7'h1D;  9'h05B: adb_d = 7'h1E;
      9'h044: adb_d = 7'h1F;  9'h03C: adb_d = 7'h20;  9'h054: adb_d = 7'h21;
      9'h043: adb_d = 7'h22;  9'h04D: adb_d = 7'h23;  9'h05A: adb_d = 7'h24;
      9'h04B: adb_d = 7'h25;  9'h03B: adb_d = 7'h26;  9'h052: adb_d = 7'h27;
      9'h042: adb_d = 7'h28;  9'h04C: adb_d = 7'h29;  9'h05D: adb_d = 7'h2A;
      9'h041: adb_d = 7'h2B;  9'h04A: adb_d = 7'h2C;  9'h031: adb_d = 7'h2D;
      9'h03A: adb_d = 7'h2E;  9'h049: adb_d = 7'h2F;  9'h00D: adb_d = 7'h30;
      9'h029: adb_d = 7'h31;  9'h00E: adb_d = 7'h32;  9'h066: adb_d = 7'h33;
      9'h076: adb_d = 7'h35;  9'h014: adb_d = 7'h36;  9'h012: adb_d = 7'h38;
      9'h058: adb_d = 7'h39;  9'h011: adb_d = 7'h3A;  9'h059: adb_d = 7'h7B;
      9'h11F: adb_d = 7'h37;  9'h127: adb_d = 7'h37;  9'h114: adb_d = 7'h7D;
      9'h111: adb_d = 7'h7C;  9'h16B: adb_d = 7'h3B;  9'h174: adb_d = 7'h3C;
      9'h172: adb_d = 7'h3D;  9'h175: adb_d = 7'h3E;  9'h15A: adb_d = 7'h4C;
      9'h171: adb_d = 7'h75;
      default: hit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit <= 1'b0;
      adb <= 7'h00;
    end else begin
      hit <= hit_d;
      adb <= adb_d;
    end
  end

endmodule

// File: rtl/adb_kbd_queue.sv
// rtl/adb_kbd_queue.sv - PS/2 scancode parser, ADB translation and key event FIFO
// Ports: clk, reset (sync, active-high); bus (adb_kbd_queue_if.slave) carries
// ps2_code/ps2_valid in, pop/flush in, key_code/key_up/key_valid/modifiers/
// count/overflow out. Optional: ADB_KBD_REPEAT_FILTER_EN drops typematic
// repeat makes using a 128-bit key-down map.
import adb_kbd_pkg::*;

module adb_kbd_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic           clk,
  input logic           reset,
  adb_kbd_queue_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'(PS_IDLE);
  localparam logic [2:0] S_EXT     = 3'(PS_EXT);
  localparam logic [2:0] S_BRK     = 3'(PS_BRK);
  localparam logic [2:0] S_EXT_BRK = 3'(PS_EXT_BRK);
  localparam logic [2:0] S_SKIP    = 3'(PS_SKIP);

  // ---------------- parser ----------------
  logic [2:0] state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       ev_now, ext_now, brk_now;

  assign ext_now = (state_q == S_EXT) || (state_q == S_EXT_BRK);
  assign brk_now = (state_q == S_BRK) || (state_q == S_EXT_BRK);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    ev_now  = 1'b0;
    if (bus.ps2_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.ps2_code == PS2_EXT) begin
            state_d = S_EXT;
          end else if (bus.ps2_code == PS2_BRK) begin
            state_d = S_BRK;
          end else if (bus.ps2_code == PS2_PAUSE) begin
            state_d = S_SKIP;
            skip_d  = PAUSE_SKIP_LEN;
          end else if (!is_ps2_noise(bus.ps2_code)) begin
            ev_now = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.ps2_code == PS2_BRK) begin
            state_d = S_EXT_BRK;
          end else begin
            ev_now  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          ev_now  = 1'b1;
          state_d = S_IDLE;
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d  = 3'd0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // ---------------- lookup stage ----------------
  // The ROM registers every cycle; ev_pend_q marks which results are real events.
  logic       lk_hit;
  logic [6:0] lk_adb;
  logic       ev_pend_q, ev_up_q;

  adb_kbd_xlate u_xlate (
    .clk   (clk),
    .reset (reset),
    .ext   (ext_now),
    .code  (bus.ps2_code),
    .hit   (lk_hit),
    .adb   (lk_adb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_pend_q <= 1'b0;
      ev_up_q   <= 1'b0;
    end else begin
      ev_pend_q <= ev_now;
      ev_up_q   <= brk_now;
    end
  end

  logic lk_event, lk_make, repeat_make, push;
  assign lk_event = ev_pend_q && lk_hit;
  assign lk_make  = lk_event && !ev_up_q;

`ifdef ADB_KBD_REPEAT_FILTER_EN
  logic [127:0] down_q;
  assign repeat_make = lk_make && down_q[lk_adb];

  always_ff @(posedge clk) begin
    if (reset) begin
      down_q <= '0;
    end else if (lk_event) begin
      down_q[lk_adb] <= !ev_up_q;
    end
  end
`else
  assign repeat_make = 1'b0;
`endif

  assign push = lk_event && !repeat_make;

  // ---------------- modifiers ----------------
  // Left/right keys are tracked separately so releasing one side keeps the
  // modifier active while the other is still held.
  logic sh_l_q, sh_r_q, ctl_l_q, ctl_r_q, opt_l_q, opt_r_q, cmd_q, caps_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      {sh_l_q, sh_r_q, ctl_l_q, ctl_r_q, opt_l_q, opt_r_q, cmd_q, caps_q} <= '0;
    end else if (lk_event) begin
      case (lk_adb)
        ADB_LSHIFT: sh_l_q  <= !ev_up_q;
        ADB_RSHIFT: sh_r_q  <= !ev_up_q;
        ADB_LCTRL:  ctl_l_q <= !ev_up_q;
        ADB_RCTRL:  ctl_r_q <= !ev_up_q;
        ADB_LOPT:   opt_l_q <= !ev_up_q;
        ADB_ROPT:   opt_r_q <= !ev_up_q;
        ADB_CMD:    cmd_q   <= !ev_up_q;
        ADB_CAPS:   if (lk_make && !repeat_make) caps_q <= !caps_q;
        default: ;
      endcase
    end
  end

  assign bus.modifiers = {cmd_q, opt_l_q | opt_r_q, caps_q,
                          ctl_l_q | ctl_r_q, sh_l_q | sh_r_q};

  // ---------------- FIFO ----------------
  kbd_event_t    mem [DEPTH];
  kbd_event_t    last_q, head;
  logic [CW-2:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          empty, full, pop_ok, push_ok, drop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = bus.pop && !empty;
  // A pop at full frees the slot this push takes, so both proceed.
  assign push_ok = push && !bus.flush && (!full || pop_ok);
  assign drop    = push && !bus.flush && full && !pop_ok;

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= '{up: ev_up_q, code: lk_adb};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      // Remembers the head so the outputs hold steady once the queue drains.
      if (!empty) last_q <= mem[rd_ptr];
      if (drop) overflow_q <= 1'b1;
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
    end
  end

  assign head          = empty ? last_q : mem[rd_ptr];
  assign bus.key_code  = head.code;
  assign bus.key_up    = head.up;
  assign bus.key_valid = !empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_adb_kbd_queue.sv
// tb/tb_adb_kbd_queue.sv - self-checking bench for adb_kbd_queue
module tb_adb_kbd_queue;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
`ifdef ADB_KBD_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adb_kbd_queue_if #(.CW(CW)) bus ();

  adb_kbd_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit up;
    int code;
  } ev_t;

  int  lut [int];       // {ext,code} -> ADB keycode, only keys the bench uses
  ev_t mq [$];
  ev_t m_last;
  bit  held [128];
  bit  m_caps, m_ovf;
  int  m_prefix;        // 0 none, 1 after E0, 2 after F0, 3 after E0 F0
  int  m_skip;          // bytes of a Pause sequence still to swallow
  bit  p_v, p_up;
  int  p_key;

  task automatic model_reset();
    mq.delete();
    m_last = '{0, 0};
    foreach (held[i]) held[i] = 1'b0;
    m_caps = 0; m_ovf = 0; m_prefix = 0; m_skip = 0;
    p_v = 0; p_up = 0; p_key = 0;
  endtask

  // Advances the model by one clock edge with the inputs seen at that edge.
  task automatic model_step(input bit v, input int code, input bit pp, input bit fl);
    bit  push, popok, dup;
    ev_t e;
    int  a;
    push = 0;
    if (mq.size() > 0) m_last = mq[0];
    // the byte strobed one cycle ago reaches the queue at this edge
    if (p_v && lut.exists(p_key)) begin
      a = lut[p_key];
      e.up = p_up; e.code = a;
      if (!p_up) begin
        dup = held[a];
        if (a == 'h39 && !(FILT && dup)) m_caps = !m_caps;
        held[a] = 1;
        push = !(FILT && dup);
      end else begin
        held[a] = 0;
        push = 1;
      end
    end
    if (fl) begin
      mq.delete();
    end else begin
      popok = pp && (mq.size() > 0);
      if (push && mq.size() == DEPTH && !popok) begin
        m_ovf = 1;
      end else begin
        if (popok) void'(mq.pop_front());
        if (push) mq.push_back(e);
      end
    end
    p_v = 0;
    if (v) begin
      if (m_skip > 0) begin
        m_skip--;
      end else if (m_prefix == 0 && code == 'hE0) m_prefix = 1;
      else if (m_prefix == 0 && code == 'hF0) m_prefix = 2;
      else if (m_prefix == 1 && code == 'hF0) m_prefix = 3;
      else if (m_prefix == 0 && code == 'hE1) m_skip = 7;
      else if (m_prefix == 0 && (code == 'hAA || code == 'hFA || code == 'hEE || code == 'hFE)) begin
      end else begin
        p_v = 1;
        p_up = (m_prefix >= 2);
        p_key = ((m_prefix == 1 || m_prefix == 3) ? 'h100 : 0) | code;
        m_prefix = 0;
      end
    end
  endtask

  function automatic int m_mods();
    return {27'd0, held['h37], held['h3A] | held['h7C], m_caps,
            held['h36] | held['h7D], held['h38] | held['h7B]};
  endfunction

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("key_valid", int'(bus.key_valid), int'(mq.size() > 0));
      chk("count", int'(bus.count), mq.size());
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("modifiers", int'(bus.modifiers), m_mods());
      chk("key_code", int'(bus.key_code), (mq.size() > 0) ? mq[0].code : m_last.code);
      chk("key_up", int'(bus.key_up), int'((mq.size() > 0) ? mq[0].up : m_last.up));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [7:0] c, input bit pp, input bit fl);
    @(negedge clk);
    #1;
    bus.ps2_valid = v;
    bus.ps2_code  = c;
    bus.pop       = pp;
    bus.flush     = fl;
    model_step(v, int'(c), pp, fl);
  endtask

  task automatic send(input logic [7:0] c);
    cyc(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    idle();
    for (int i = 0; i < 4 * DEPTH && mq.size() > 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle();
  endtask

  logic [7:0] many [11] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h33, 8'h34,
                            8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32};

  initial begin
    lut['h01C] = 'h00; lut['h01B] = 'h01; lut['h023] = 'h02; lut['h02B] = 'h03;
    lut['h033] = 'h04; lut['h034] = 'h05; lut['h01A] = 'h06; lut['h022] = 'h07;
    lut['h021] = 'h08; lut['h02A] = 'h09; lut['h032] = 'h0B; lut['h012] = 'h38;
    lut['h058] = 'h39; lut['h11F] = 'h37; lut['h059] = 'h7B;

    bus.ps2_valid = 0; bus.ps2_code = 0; bus.pop = 0; bus.flush = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_valid", int'(bus.key_valid), 0);
    chk("rst_mods", int'(bus.modifiers), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_code", int'(bus.key_code), 0);
    #1 reset = 0;
    chk_en = 1;

    // A make then break
    send(8'h1C);
    idle(); chk("lat_n1_valid", int'(bus.key_valid), 0);
    idle(); chk("lat_n2_valid", int'(bus.key_valid), 1);
    send(8'hF0); send(8'h1C); idle(); idle();
    chk("a_count", int'(bus.count), 2);
    chk("a_head_up", int'(bus.key_up), 0);
    cyc(0, 8'h00, 1, 0); idle();
    chk("a_second_up", int'(bus.key_up), 1);
    chk("a_second_code", int'(bus.key_code), 'h00);
    drain();

    // shift held around A
    send(8'h12); idle(); idle();
    chk("shift_on", int'(bus.modifiers[0]), 1);
    send(8'h1C); send(8'hF0); send(8'h12); idle(); idle();
    chk("shift_off", int'(bus.modifiers[0]), 0);
    chk("shift_count", int'(bus.count), 3);
    chk("shift_head", int'(bus.key_code), 'h38);
    send(8'hF0); send(8'h1C);
    drain();

    // caps lock toggling
    send(8'h58); idle(); idle();
    chk("caps_1", int'(bus.modifiers[2]), 1);
    send(8'hF0); send(8'h58); idle(); idle();
    chk("caps_2", int'(bus.modifiers[2]), 1);
    send(8'h58); idle(); idle();
    chk("caps_3", int'(bus.modifiers[2]), 0);
    chk("caps_count", int'(bus.count), 3);
    drain();

    // extended command key, then a Pause sequence that yields nothing
    send(8'hE0); send(8'h1F);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(); idle();
    chk("cmd_count", int'(bus.count), 1);
    chk("cmd_code", int'(bus.key_code), 'h37);
    chk("cmd_mod", int'(bus.modifiers[4]), 1);
    send(8'h1C); idle(); idle();
    chk("after_pause", int'(bus.count), 2);
    send(8'hE0); send(8'hF0); send(8'h1F); send(8'hF0); send(8'h1C);
    send(8'hAA); send(8'hE0); send(8'h12);
    drain();

    // push with pop while empty, then push discarded by flush
    send(8'h1B); cyc(0, 8'h00, 1, 0); idle();
    chk("empty_pushpop", int'(bus.count), 1);
    drain();
    send(8'hF0); send(8'h1B); cyc(0, 8'h00, 0, 1); idle();
    chk("flush_push", int'(bus.count), 0);

    // overflow, push+pop at full, flush
    for (int i = 0; i < DEPTH + 2; i++) send(many[i]);
    idle(); idle();
    chk("full_count", int'(bus.count), DEPTH);
    chk("full_ovf", int'(bus.overflow), 1);
    send(many[10]); cyc(0, 8'h00, 1, 0); idle();
    chk("full_pushpop", int'(bus.count), DEPTH);
    cyc(0, 8'h00, 0, 1); idle();
    chk("flush_count", int'(bus.count), 0);
    chk("flush_valid", int'(bus.key_valid), 0);
    chk("flush_ovf", int'(bus.overflow), 1);
    for (int i = 0; i < 11; i++) begin
      send(8'hF0); send(many[i]);
    end
    idle(); idle(); cyc(0, 8'h00, 0, 1); idle();

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    idle(); idle();
    chk("repeat_count", int'(bus.count), FILT ? 2 : 4);
    drain();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
